// File: rtl/core_mem_arbiter_if.sv
// Bus bundle between core_mem_arbiter, its two requesters (fetch, data) and the memory port.
// slave: arbiter view; master: requester/memory-side view.
interface core_mem_arbiter_if;
   logic        i_ren;
   logic [31:0] i_raddr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_ren;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        m_ren;
   logic        m_wen;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ready;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   modport slave (
      input  i_ren, i_raddr,
      output i_gnt, i_rvalid, i_rdata,
      input  d_ren, d_wen, d_addr, d_wdata, d_wstrb,
      output d_gnt, d_rvalid, d_rdata,
      output m_ren, m_wen, m_addr, m_wdata, m_wstrb,
      input  m_ready, m_rvalid, m_rdata
   );

   modport master (
      output i_ren, i_raddr,
      input  i_gnt, i_rvalid, i_rdata,
      output d_ren, d_wen, d_addr, d_wdata, d_wstrb,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_ren, m_wen, m_addr, m_wdata, m_wstrb,
      output m_ready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between fetch reads and data loads/stores; one read outstanding.
// Optional stall counters (perf_i_stall/perf_d_stall) when MEM_ARB_PERF_EN is defined.
module core_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]         perf_i_stall,
   output logic [31:0]         perf_d_stall,
`endif
   core_mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;
   typedef enum logic [1:0] {W_NONE, W_I, W_D} winner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      state, state_nxt;
   winner_t     winner;
   logic [3:0]  starve_cnt, starve_nxt;
   logic        i_req, d_req, d_is_wr, can_issue, fetch_pri;
   logic        i_gnt_c, d_gnt_c;
   logic        m_ren_c, m_wen_c;
   logic [31:0] m_addr_c, m_wdata_c;
   logic [3:0]  m_wstrb_c;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   always_comb begin
      i_req     = bus.i_ren;
      d_req     = bus.d_ren | bus.d_wen;
      d_is_wr   = bus.d_wen;
      can_issue = (state == IDLE) | bus.m_rvalid;
      fetch_pri = (starve_cnt >= LIMIT);

      winner = W_NONE;
      if (i_req && d_req)
         winner = fetch_pri ? W_I : W_D;
      else if (i_req)
         winner = W_I;
      else if (d_req)
         winner = W_D;

      m_ren_c   = 1'b0;
      m_wen_c   = 1'b0;
      m_addr_c  = '0;
      m_wdata_c = '0;
      m_wstrb_c = '0;
      case (winner)
         W_I: begin
            m_ren_c  = can_issue;
            m_addr_c = bus.i_raddr;
         end
         W_D: begin
            m_ren_c   = can_issue & ~d_is_wr;
            m_wen_c   = can_issue & d_is_wr;
            m_addr_c  = bus.d_addr;
            m_wdata_c = bus.d_wdata;
            m_wstrb_c = bus.d_wstrb;
         end
         default: ;
      endcase

      i_gnt_c = (winner == W_I) & can_issue & bus.m_ready;
      d_gnt_c = (winner == W_D) & can_issue & bus.m_ready;

      // A granted write never occupies the read slot, so it only retires a returning read.
      state_nxt = state;
      if (i_gnt_c)
         state_nxt = RD_I;
      else if (d_gnt_c && !d_is_wr)
         state_nxt = RD_D;
      else if (bus.m_rvalid)
         state_nxt = IDLE;

      starve_nxt = starve_cnt;
      if (i_gnt_c || !bus.i_ren)
         starve_nxt = '0;
      else if (starve_cnt != 4'hF)
         starve_nxt = starve_cnt + 4'd1;
   end

   assign bus.i_gnt    = i_gnt_c;
   assign bus.d_gnt    = d_gnt_c;
   assign bus.m_ren    = m_ren_c;
   assign bus.m_wen    = m_wen_c;
   assign bus.m_addr   = m_addr_c;
   assign bus.m_wdata  = m_wdata_c;
   assign bus.m_wstrb  = m_wstrb_c;
   assign bus.i_rvalid = bus.m_rvalid & (state == RD_I);
   assign bus.d_rvalid = bus.m_rvalid & (state == RD_D);
   assign bus.i_rdata  = bus.m_rdata;
   assign bus.d_rdata  = bus.m_rdata;

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_i_stall <= '0;
         perf_d_stall <= '0;
      end else begin
         if (bus.i_ren && !i_gnt_c)
            perf_i_stall <= perf_i_stall + 32'd1;
         if (d_req && !d_gnt_c)
            perf_d_stall <= perf_d_stall + 32'd1;
      end
   end
`endif

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Shares one single-ported synchronous memory port between the fetch read port and the data load/store port of the core. Sits between core_fetch / the memory stage and the memory. Tracks the single outstanding read so that read data returns to the correct requester. Data accesses have fixed priority, and a starvation counter guarantees fetch forward progress.

Parameters:
STARVE_LIMIT, 4, number of consecutive denied fetch-request cycles after which fetch wins the next contended arbitration; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
i_ren  in  1  fetch read request
i_raddr  in  32  fetch read address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  i_rdata valid this cycle
i_rdata  out  32  fetch read data
d_ren  in  1  data read request
d_wen  in  1  data write request
d_addr  in  32  data address
d_wdata  in  32  store data
d_wstrb  in  4  byte enables for store
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  d_rdata valid this cycle
d_rdata  out  32  load data
m_ren  out  1  memory read strobe
m_wen  out  1  memory write strobe
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_wstrb  out  4  memory byte enables
m_ready  in  1  memory accepts the strobe this cycle
m_rvalid  in  1  read data returning
m_rdata  in  32  read data

Behaviour:
- States: IDLE (no read outstanding), RD_I (fetch read outstanding), RD_D (data read outstanding). At most one read is outstanding.
- can_issue = (state==IDLE) | m_rvalid. A new access may issue in the cycle the previous read returns.
- i_req = i_ren. d_req = d_ren | d_wen. If d_wen and d_ren are both set, the access is a write and d_ren is ignored.
- fetch_pri = (starve_cnt >= STARVE_LIMIT).
- Winner:
  - both requesting: fetch if fetch_pri, otherwise data;
  - one requesting: that requester;
  - neither: none.
- Memory strobes:
  - m_ren / m_wen are asserted only when can_issue and a winner exists.
  - m_addr, m_wdata and m_wstrb are muxed from the winner.
  - For a fetch winner: m_wdata=0 and m_wstrb=0.
  - With no winner: m_addr=0, m_wdata=0, m_wstrb=0.
- Grant: x_gnt = winner==x & can_issue & m_ready. All strobes and grants are combinational, with zero added latency.
- Requester hold rule: a requester holds its request and payload stable until its gnt is seen. The arbiter does not latch the payload.
- Next state:
  - read granted → RD_I or RD_D by owner;
  - else if m_rvalid → IDLE;
  - else hold.
  - A granted write leaves the state at IDLE (or returns it to IDLE if m_rvalid).
  - Writes produce no response.
- Read return:
  - i_rvalid = m_rvalid & state==RD_I; d_rvalid = m_rvalid & state==RD_D.
  - i_rdata = d_rdata = m_rdata, unqualified.
  - m_rvalid in IDLE is ignored: no rvalid is forwarded.
- starve_cnt, width 4:
  - cleared on i_gnt, or when i_ren is low;
  - otherwise incremented, saturating at 15, when i_ren=1 and i_gnt=0.
- Reset (rst=0): state←IDLE and starve_cnt←0.
  - Outputs in the first cycle after reset: i_rvalid=d_rvalid=0, and no strobes unless requests are present.
  - Reset mid-read drops the outstanding read, and a late m_rvalid is discarded.
- Latency: a read granted in cycle N returns no earlier than N+1 (when m_rvalid is asserted).

Optional Feature:
Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_i_stall (32) and perf_d_stall (32).
  - perf_i_stall increments each cycle i_ren=1 and i_gnt=0.
  - perf_d_stall increments each cycle d_req=1 and d_gnt=0.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
1. Fetch only: i_ren=1, i_raddr=0x100, m_ready=1, memory with 1-cycle latency.
   - Required: i_gnt=1 in cycle 0 with m_addr=0x100.
   - Required: i_rvalid=1 in cycle 1 with the memory word.
   - Required: back-to-back fetches to 0x104, 0x108 granted every cycle.
2. Contention: i_ren and d_ren held continuously, STARVE_LIMIT=4.
   - Required: data granted 4 consecutive accesses, then fetch granted once.
   - Required: starve_cnt returns to 0 and the pattern repeats.
3. Routing: grant data read at 0x200 (m_rdata=0xDEADBEEF), then fetch the next cycle.
   - Required: d_rvalid=1 and i_rvalid=0 on the return.
   - Required: fetch issued in the same cycle as m_rvalid.
4. Write: d_wen=1 and d_ren=1, d_addr=0x300, d_wstrb=0x3, m_ready=1.
   - Required: m_wen=1, m_ren=0, m_wstrb=0x3, d_gnt=1.
   - Required: state stays IDLE and no d_rvalid follows.
5. Backpressure: m_ready=0 for 3 cycles with i_ren=1.
   - Required: i_gnt=0 throughout with m_ren=1 and m_addr stable.
   - Required: grant in the first cycle m_ready=1.
6. Reset mid-read: grant a data read, assert rst=0 for one cycle, then deliver m_rvalid.
   - Required: d_rvalid=0 and i_rvalid=0, state IDLE.
   - Required (MEM_ARB_PERF_EN): counters read 0.
